// File: rtl/fact_pkg.sv
// Shared constants for the factorial MMIO front end: register map, bit positions, FSM states.
package fact_pkg;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_N      = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_RESULT = 2'd3;

    localparam int CTRL_GO = 0;
    localparam int CTRL_IE = 1;

    localparam int ST_DONE = 0;
    localparam int ST_ERR  = 1;
    localparam int ST_BUSY = 2;
    localparam int ST_TO   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        ARM   = 2'd2,
        BUSY  = 2'd3
    } state_e;

endpackage

// File: rtl/fact_mmio_if.sv
// Word-addressed CPU-side bus into the factorial front end, plus its interrupt line.
interface fact_mmio_if;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    modport master (output sel, output we, output addr, output wd, input rd, input irq);
    modport slave  (input sel, input we, input addr, input wd, output rd, output irq);
endinterface

// File: rtl/fact_mmio.sv
// MMIO front end for the factorial core: operand/control registers, run sequencer with
// timeout, sticky status and result capture, interrupt generation.
module fact_mmio
    import fact_pkg::*;
#(
    parameter int N_W    = 4,
    parameter int RES_W  = 4,
    parameter int TO_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    fact_mmio_if.slave       bus,
    output logic [N_W-1:0]   fc_n,
    output logic             fc_go,
    input  logic             fc_done,
    input  logic             fc_err,
    input  logic [RES_W-1:0] fc_nf
);

    localparam int CNT_W = $clog2(TO_CYC);

    state_e             r_state;
    state_e             w_next;
    logic [N_W-1:0]     r_n;
    logic [N_W-1:0]     r_n_lat;
    logic               r_ie;
    logic               r_done;
    logic               r_err;
    logic               r_to;
    logic [RES_W-1:0]   r_result;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        w_rd;
    logic               w_wr;
    logic               w_go_req;
    logic               w_start;
    logic               w_w1c;
    logic               w_cnt_last;
    logic               w_busy;
    logic               w_unused_wd;

    assign w_wr        = bus.sel & bus.we;
    assign w_go_req    = w_wr & (bus.addr == A_CTRL) & bus.wd[CTRL_GO];
    assign w_start     = (r_state == IDLE) & w_go_req;
    assign w_w1c       = w_wr & (bus.addr == A_STATUS) & bus.wd[ST_DONE];
    assign w_cnt_last  = (r_cnt == CNT_W'(TO_CYC - 1));
    assign w_busy      = (r_state != IDLE);
    assign w_unused_wd = ^bus.wd;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; ARM exists so a core status left over from the last run is never sampled
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_go_req ? START : IDLE;
            START:   w_next = ARM;
            ARM:     w_next = BUSY;
            BUSY: begin
                if (fc_done | fc_err | w_cnt_last) begin
                    w_next = IDLE;
                end else begin
                    w_next = BUSY;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Software-visible config: operand, interrupt enable, and the operand snapshot for the run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n     <= {N_W{1'b0}};
            r_ie    <= 1'b0;
            r_n_lat <= {N_W{1'b0}};
        end else begin
            if (w_wr && (bus.addr == A_N)) begin
                r_n <= bus.wd[N_W-1:0];
            end
            if (w_wr && (bus.addr == A_CTRL)) begin
                r_ie <= bus.wd[CTRL_IE];
            end
            if (w_start) begin
                r_n_lat <= r_n;
            end
        end
    end

    // Sticky status and result; hardware set outranks a same-cycle W1C
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_to     <= 1'b0;
            r_result <= {RES_W{1'b0}};
        end else if (w_start) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_to   <= 1'b0;
        end else if ((r_state == BUSY) && fc_err) begin
            r_done <= 1'b1;
            r_err  <= 1'b1;
        end else if ((r_state == BUSY) && fc_done) begin
            r_done   <= 1'b1;
            r_result <= fc_nf;
        end else if ((r_state == BUSY) && w_cnt_last) begin
            r_done <= 1'b1;
            r_err  <= 1'b1;
            r_to   <= 1'b1;
        end else if (w_w1c) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_to   <= 1'b0;
        end
    end

    // Timeout counter, only advances in BUSY and is left before it could wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_start) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if ((r_state == BUSY) && !w_cnt_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Read mux
    always_comb begin
        w_rd = 32'd0;
        if (bus.sel) begin
            case (bus.addr)
                A_CTRL:   w_rd = {30'd0, r_ie, 1'b0};
                A_N:      w_rd = {{(32-N_W){1'b0}}, r_n};
                A_STATUS: w_rd = {28'd0, r_to, w_busy, r_err, r_done};
                A_RESULT: w_rd = {{(32-RES_W){1'b0}}, r_result};
                default:  w_rd = 32'd0;
            endcase
        end else begin
            w_rd = 32'd0;
        end
    end

    assign bus.rd  = w_rd;
    assign bus.irq = r_done & r_ie;
    assign fc_n    = r_n_lat;
    assign fc_go   = (r_state == START);

endmodule

// File: tb/tb_fact_mmio.sv
// Randomized self-checking bench for fact_mmio against a run-level reference model.
module tb_fact_mmio;
    import fact_pkg::*;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] fc_n;
    logic       fc_go;
    logic       fc_done = 1'b0;
    logic       fc_err = 1'b0;
    logic [3:0] fc_nf = 4'd0;

    fact_mmio_if bus();

    fact_mmio #(.N_W(4), .RES_W(4), .TO_CYC(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .fc_n    (fc_n),
        .fc_go   (fc_go),
        .fc_done (fc_done),
        .fc_err  (fc_err),
        .fc_nf   (fc_nf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: what software should observe between runs
    logic [3:0] m_n = 4'd0;
    logic       m_ie = 1'b0;
    logic [3:0] m_result = 4'd0;
    logic [3:0] m_status = 4'd0;

    int         go_cnt = 0;
    logic [3:0] go_n = 4'd0;

    // count start pulses and the operand seen with each one
    always @(negedge clk) begin
        if (fc_go === 1'b1) begin
            go_cnt = go_cnt + 1;
            go_n   = fc_n;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.sel = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wd = d;
        @(posedge clk);
        #1;
        bus.sel = 1'b0; bus.we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.sel = 1'b1; bus.we = 1'b0; bus.addr = a;
        #1;
        d = bus.rd;
        @(posedge clk);
        #1;
        bus.sel = 1'b0;
    endtask

    // kind: 0 done, 1 err, 2 done+err, 3 no response (timeout); d = BUSY cycle of the response
    task automatic run_one(input int kind, input int d, input bit stale,
                           input bit wr_n, input logic [31:0] n_val,
                           input bit extra_go, input bit mid_n, input logic [31:0] mid_val,
                           input bit collide, input logic [3:0] nf);
        logic [31:0] rdv;
        logic [3:0]  run_n;
        logic        ie;
        logic        ie2;
        int          last_k;
        int          k;
        if (wr_n) begin
            bus_write(A_N, n_val);
            m_n = n_val[3:0];
            bus_read(A_N, rdv);
            check("n_readback", rdv, {28'd0, m_n});
        end
        run_n  = m_n;
        ie     = 1'($urandom_range(0, 1));
        go_cnt = 0;
        bus_write(A_CTRL, {30'd0, ie, 1'b1});
        m_ie     = ie;
        m_status = 4'd0;
        last_k   = (kind == 3) ? TO - 1 : d;
        for (int c = 0; c <= 2 + last_k; c++) begin
            @(negedge clk);
            k       = c - 2;
            fc_done = (stale && c < 2) || ((kind == 0 || kind == 2) && c >= 2 && k == d);
            fc_err  = (kind == 1 || kind == 2) && c >= 2 && k == d;
            fc_nf   = (c >= 2 && k == d) ? nf : 4'($urandom);
            bus.sel = 1'b0; bus.we = 1'b0;
            if (c == 0) begin
                bus.sel = 1'b1; bus.addr = A_STATUS;
                #1;
                check("busy_status", bus.rd, 32'h4);
                check("irq_in_run", {31'd0, bus.irq}, 32'd0);
            end else if (c == 1 && extra_go) begin
                ie2 = 1'($urandom_range(0, 1));
                bus.sel = 1'b1; bus.we = 1'b1; bus.addr = A_CTRL; bus.wd = {30'd0, ie2, 1'b1};
                m_ie = ie2;
            end else if (c == 2 && mid_n) begin
                bus.sel = 1'b1; bus.we = 1'b1; bus.addr = A_N; bus.wd = mid_val;
                m_n = mid_val[3:0];
            end else if (c == 2 + last_k && collide) begin
                bus.sel = 1'b1; bus.we = 1'b1; bus.addr = A_STATUS; bus.wd = 32'd1;
            end
            #1;
            check("fc_n_hold", {28'd0, fc_n}, {28'd0, run_n});
            @(posedge clk);
        end
        @(negedge clk);
        fc_done = 1'b0; fc_err = 1'b0;
        bus.sel = 1'b0; bus.we = 1'b0;
        case (kind)
            0:       begin m_result = nf; m_status = 4'b0001; end
            1, 2:    m_status = 4'b0011;
            default: m_status = 4'b1011;
        endcase
        check("go_pulses", go_cnt, 1);
        check("go_operand", {28'd0, go_n}, {28'd0, run_n});
        check("irq_done", {31'd0, bus.irq}, {31'd0, m_ie});
        bus_read(A_STATUS, rdv);
        check("status", rdv, {28'd0, m_status});
        bus_read(A_RESULT, rdv);
        check("result", rdv, {28'd0, m_result});
        bus_read(A_CTRL, rdv);
        check("ctrl_ie", rdv, {30'd0, m_ie, 1'b0});
        if ($urandom_range(0, 1) == 1) begin
            bus_write(A_STATUS, 32'd1);
            m_status = 4'd0;
            bus_read(A_STATUS, rdv);
            check("status_w1c", rdv, 32'd0);
            check("irq_w1c", {31'd0, bus.irq}, 32'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        bus.sel = 1'b1; bus.we = 1'b0;
        bus.addr = A_STATUS; #1;
        check({tag, "_status"}, bus.rd, 32'd0);
        bus.addr = A_RESULT; #1;
        check({tag, "_result"}, bus.rd, 32'd0);
        bus.addr = A_CTRL; #1;
        check({tag, "_ctrl"}, bus.rd, 32'd0);
        check({tag, "_fc_go"}, {31'd0, fc_go}, 32'd0);
        check({tag, "_fc_n"}, {28'd0, fc_n}, 32'd0);
        check({tag, "_irq"}, {31'd0, bus.irq}, 32'd0);
        bus.sel = 1'b0; #1;
        check({tag, "_rd_unsel"}, bus.rd, 32'd0);
        m_n = 4'd0; m_ie = 1'b0; m_result = 4'd0; m_status = 4'd0;
    endtask

    initial begin
        int kind;
        bus.sel = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wd = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        @(negedge clk);
        rst_n = 1'b1;

        run_one(0, 3, 1'b0, 1'b1, 32'd3,  1'b0, 1'b0, 32'd0, 1'b0, 4'd6);
        run_one(1, 2, 1'b0, 1'b1, 32'd13, 1'b0, 1'b0, 32'd0, 1'b0, 4'd9);
        run_one(0, 5, 1'b0, 1'b1, 32'd3,  1'b1, 1'b1, 32'd5, 1'b0, 4'd6);
        run_one(0, 1, 1'b0, 1'b0, 32'd0,  1'b0, 1'b0, 32'd0, 1'b0, 4'd2);
        run_one(3, 0, 1'b1, 1'b1, 32'd7,  1'b0, 1'b0, 32'd0, 1'b1, 4'd1);
        run_one(0, 0, 1'b1, 1'b1, 32'd4,  1'b0, 1'b0, 32'd0, 1'b0, 4'd8);
        run_one(0, TO - 1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 4'd11);
        run_one(2, 4, 1'b1, 1'b0, 32'd0,  1'b1, 1'b0, 32'd0, 1'b1, 4'd12);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            run_one(kind, $urandom_range(0, TO - 1), 1'($urandom), 1'($urandom), $urandom,
                    1'($urandom), 1'($urandom), $urandom, 1'($urandom), 4'($urandom));
        end

        // reset in the middle of BUSY
        bus_write(A_N, 32'd9);
        bus_write(A_CTRL, 32'h3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_busy");
        @(negedge clk);
        rst_n = 1'b1;

        // reset while the start pulse is high
        bus_write(A_N, 32'd2);
        bus_write(A_CTRL, 32'h1);
        @(negedge clk);
        check("go_before_rst", {31'd0, fc_go}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_start");
        @(negedge clk);
        rst_n = 1'b1;

        run_one(0, 2, 1'b0, 1'b1, 32'd6, 1'b0, 1'b0, 32'd0, 1'b0, 4'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
